// File: rtl/pipe_pkg.sv
// Shared types and default widths for pipeline-boundary registers.
// Holds the stage state encoding and the bubble control constant.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_CTRL_W = 8;
    localparam int PIPE_CNT_W  = 16;

    localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_ZERO = '0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register: valid/ready handshake, two-entry skid, flush.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CTRL_W-1:0] CTRL_ZERO = CTRL_W'(PIPE_CTRL_ZERO);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic              in_fire;
    logic              out_fire;

    // Both handshake outputs come straight from the state flop.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        if (flush) begin
            state_d  = EMPTY;
            m_data_d = '0;
            m_ctrl_d = CTRL_ZERO;
            s_data_d = '0;
            s_ctrl_d = CTRL_ZERO;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl;
                        state_d  = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl;
                    end else if (in_fire && !out_ready) begin
                        s_data_d = in_data;
                        s_ctrl_d = in_ctrl;
                        state_d  = FULL;
                    end else if (!in_valid && out_fire) begin
                        m_ctrl_d = CTRL_ZERO;
                        state_d  = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        m_data_d = s_data_q;
                        m_ctrl_d = s_ctrl_q;
                        s_ctrl_d = CTRL_ZERO;
                        state_d  = BUSY;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    m_ctrl_d = CTRL_ZERO;
                    s_ctrl_d = CTRL_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            m_data_q <= '0;
            m_ctrl_q <= '0;
            s_data_q <= '0;
            s_ctrl_q <= '0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            m_ctrl_q <= m_ctrl_d;
            s_data_q <= s_data_d;
            s_ctrl_q <= s_ctrl_d;
        end
    end

    assign out_data = m_data_q;
    assign out_ctrl = m_ctrl_q;

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .en    (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .en    (~out_valid & out_ready),
        .count (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, skid, flush, async reset,
// and the optional performance counters (CNT_W=4).
module tb_pipe_stage_reg;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NW = 4;

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [NW-1:0] EXP_STALL  = 4'd15;
    localparam logic [NW-1:0] EXP_BUBBLE = 4'd3;
`else
    localparam logic [NW-1:0] EXP_STALL  = 4'd0;
    localparam logic [NW-1:0] EXP_BUBBLE = 4'd0;
`endif

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] bubble_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_ready = 1'b0;
        step();
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_out_valid got=%b exp=0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_in_ready got=%b exp=1", in_ready);
        end
        n_cmp++;
        if (out_data !== 64'h0 || out_ctrl !== 8'h0) begin
            n_err++;
            $display("FAIL rst_payload got=%h/%h exp=0/0", out_data, out_ctrl);
        end
        n_cmp++;
        if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data = 64'(i);
            in_ctrl = 8'h05;
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 64'(i) || out_ctrl !== 8'h05) begin
                n_err++;
                $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/05",
                         i, out_valid, out_data, out_ctrl, 64'(i));
            end
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream_rdy_%0d got=%b exp=1", i, in_ready);
            end
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h0) begin
            n_err++;
            $display("FAIL stream_drain got=%b/%h exp=0/00", out_valid, out_ctrl);
        end
    endtask

    task automatic test_stall_skid();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 64'hA;
        in_ctrl = 8'h0A;
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || out_data !== 64'hA) begin
            n_err++;
            $display("FAIL skid_busy got=%b/%h exp=1/a", in_ready, out_data);
        end
        in_data = 64'hB;
        in_ctrl = 8'h0B;
        step();
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 64'hA) begin
            n_err++;
            $display("FAIL skid_full got=%b/%b/%h exp=0/1/a",
                     in_ready, out_valid, out_data);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_data !== 64'hB || out_ctrl !== 8'h0B || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL skid_drain1 got=%h/%h/%b exp=b/0b/1",
                     out_data, out_ctrl, in_ready);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL skid_drain2 got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 64'hA;
        in_ctrl = 8'h11;
        step();
        in_data = 64'hB;
        in_ctrl = 8'h22;
        step();
        in_data = 64'hC;
        in_ctrl = 8'h33;
        flush = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_full got=%b/%h/%b exp=0/00/1",
                     out_valid, out_ctrl, in_ready);
        end
        flush = 1'b0;
        out_ready = 1'b1;
        in_data = 64'hD;
        in_ctrl = 8'h44;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 64'hD || out_ctrl !== 8'h44) begin
            n_err++;
            $display("FAIL flush_next got=%b/%h/%h exp=1/d/44",
                     out_valid, out_data, out_ctrl);
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_no_ghost got=%b/%h exp=0", out_valid, out_data);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 64'hE;
        in_ctrl = 8'h77;
        step();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || out_ctrl !== 8'h0) begin
            n_err++;
            $display("FAIL async_rst got=%b/%h/%h exp=0/0/0",
                     out_valid, out_data, out_ctrl);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_rst_rdy got=%b exp=1", in_ready);
        end
        step();
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 64'hF;
        in_ctrl = 8'h66;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 64'hF) begin
            n_err++;
            $display("FAIL post_rst_accept got=%b/%h exp=1/f", out_valid, out_data);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_perf();
        reset = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 64'h5;
        in_ctrl = 8'h01;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        n_cmp++;
        if (stall_cnt !== EXP_STALL) begin
            n_err++;
            $display("FAIL perf_stall got=%0d exp=%0d", stall_cnt, EXP_STALL);
        end
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (bubble_cnt !== EXP_BUBBLE) begin
            n_err++;
            $display("FAIL perf_bubble got=%0d exp=%0d", bubble_cnt, EXP_BUBBLE);
        end
        out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if (stall_cnt !== EXP_STALL || bubble_cnt !== EXP_BUBBLE) begin
            n_err++;
            $display("FAIL perf_flush got=%0d/%0d exp=%0d/%0d",
                     stall_cnt, bubble_cnt, EXP_STALL, EXP_BUBBLE);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_async_reset();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
